// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev
// Description : Programmable down-counting timer peripheral. It has one-shot
//               and auto-reload modes, a preset register, a readable live
//               count and a sticky pending flag. The pending flag drives a
//               level-sensitive interrupt.
//               Defining TIMER_PRESCALE_EN adds a PRESCALE register and a
//               tick divider in front of the down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_dev #(
   parameter int PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
   localparam logic [1:0] c_ADDR_PRESET = 2'd1;
   localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
   localparam logic [1:0] c_ADDR_PSC    = 2'd3;
   localparam logic [1:0] c_MODE_RELOAD = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_en;
   logic [1:0]            r_mode;
   logic                  r_im;
   logic                  r_pend;
   logic [31:0]           r_preset;
   logic [31:0]           r_count;
   logic [PRESCALE_W-1:0] w_prescale_rd;
   logic                  w_ctrl_wr;
   logic                  w_tick;
   logic                  w_terminal;

   assign w_ctrl_wr  = we && (addr == c_ADDR_CTRL);
   // Terminal count is only recognised on a tick of an enabled, running counter
   assign w_terminal = (r_state == ST_CNT) && r_en && w_tick && (r_count <= 32'd1);
   assign irq        = r_pend & r_im;

`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] r_prescale;
   logic [PRESCALE_W-1:0] r_psc;

   assign w_tick        = (r_psc == '0);
   assign w_prescale_rd = r_prescale;

   // PRESCALE register and divider: PRESCALE+1 cycles per count decrement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prescale <= '0;
         r_psc      <= '0;
      end else begin
         if (we && (addr == c_ADDR_PSC)) begin
            r_prescale <= din[PRESCALE_W-1:0];
         end
         if ((r_state == ST_LOAD) || ((r_state == ST_CNT) && r_en && w_tick)) begin
            r_psc <= r_prescale;
         end else if ((r_state == ST_CNT) && r_en) begin
            r_psc <= r_psc - PRESCALE_W'(1);
         end
      end
   end
`else
   assign w_tick        = 1'b1;
   assign w_prescale_rd = '0;
`endif

   // Control/state machine: CTRL and PRESET registers, live count, pending flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_en     <= 1'b0;
         r_mode   <= 2'b00;
         r_im     <= 1'b0;
         r_pend   <= 1'b0;
         r_preset <= 32'd0;
         r_count  <= 32'd0;
      end else begin
         // A PRESET write only lands in the count at the next LOAD
         if (we && (addr == c_ADDR_PRESET)) begin
            r_preset <= din;
         end

         case (r_state)
            ST_IDLE: begin
               if (r_en) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (!r_en) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_count <= r_preset;
                  r_state <= ST_CNT;
               end
            end
            ST_CNT: begin
               if (!r_en) begin
                  r_state <= ST_IDLE;
               end else if (w_terminal) begin
                  r_count <= 32'd0;
                  r_state <= ST_INT;
               end else if (w_tick) begin
                  r_count <= r_count - 32'd1;
               end
            end
            default: begin
               if (r_en && (r_mode == c_MODE_RELOAD)) begin
                  r_state <= ST_LOAD;
               end else begin
                  r_en    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
         endcase

         // Setting pend has priority over the clear-on-CTRL-write
         if (w_terminal) begin
            r_pend <= 1'b1;
         end else if (w_ctrl_wr) begin
            r_pend <= 1'b0;
         end

         // Written CTRL bits override the automatic EN clear in INT
         if (w_ctrl_wr) begin
            r_en   <= din[0];
            r_mode <= din[2:1];
            r_im   <= din[3];
         end
      end
   end

   // Zero-latency read mux
   always_comb begin
      dout = 32'd0;
      case (addr)
         c_ADDR_CTRL:   dout = {27'd0, r_pend, r_im, r_mode, r_en};
         c_ADDR_PRESET: dout = r_preset;
         c_ADDR_COUNT:  dout = r_count;
         default:       dout = 32'(w_prescale_rd);
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_dev
// Description : Self-checking bench for timer_dev. Stimulus pushes expected
//               read data / irq into a scoreboard; a monitor pops and
//               compares on every read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_timer_dev;

   logic        clk;
   logic        rst;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;
   logic        rd_strobe;

   int n_chk  = 0;
   int n_fail = 0;

   string       nm_q  [$];
   logic [31:0] exp_q [$];
   logic        irq_q [$];

   timer_dev #(.PRESCALE_W(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .we   (we),
      .din  (din),
      .dout (dout),
      .irq  (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Scoreboard monitor
   string       m_nm;
   logic [31:0] m_exp;
   logic        m_irq;
   always @(posedge rd_strobe) begin
      n_chk = n_chk + 1;
      if (nm_q.size() == 0) begin
         n_fail = n_fail + 1;
         $display("FAIL sb_underflow: read strobe with empty scoreboard, dout=%h irq=%b", dout, irq);
      end else begin
         m_nm  = nm_q.pop_front();
         m_exp = exp_q.pop_front();
         m_irq = irq_q.pop_front();
         if ((dout !== m_exp) || (irq !== m_irq)) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got dout=%h irq=%b, expected dout=%h irq=%b at %0t",
                     m_nm, dout, irq, m_exp, m_irq, $time);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      @(posedge clk);
      #1;
      we   = 1'b0;
   endtask

   task automatic chk(input logic [1:0] a, input logic [31:0] e, input logic ei, input string nm);
      addr = a;
      nm_q.push_back(nm);
      exp_q.push_back(e);
      irq_q.push_back(ei);
      #1 rd_strobe = 1'b1;
      #1 rd_strobe = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "watchdog expired");
   end

   logic [31:0] cnt_tab  [0:10];
   logic [31:0] ctrl_tab [0:10];
   logic [31:0] psc_exp;

   initial begin
      rst       = 1'b0;
      we        = 1'b0;
      addr      = 2'd0;
      din       = 32'd0;
      rd_strobe = 1'b0;
      cnt_tab   = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
      ctrl_tab  = '{32'hB, 32'hB, 32'hB, 32'hB, 32'h1B, 32'hB, 32'hB, 32'hB, 32'hB, 32'h1B, 32'h1B};

      // Reset values
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) chk(2'(i), 32'd0, 1'b0, "reset_value");

      // Reset asserted while counting with COUNT=50
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h1);
      step(52);
      chk(2'd2, 32'd50, 1'b0, "rst_pre_count");
      chk(2'd0, 32'h1, 1'b0, "rst_pre_ctrl");
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) chk(2'(i), 32'd0, 1'b0, "in_reset");
      step(1);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) chk(2'(i), 32'd0, 1'b0, "after_reset");
      step(2);
      chk(2'd2, 32'd0, 1'b0, "after_reset_idle");

      // One-shot, PRESET=5: irq rises at the 7th edge after the CTRL write
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 7; k++) begin
         step(1);
         chk(2'd2, (k == 1) ? 32'd0 : 32'(7 - k), (k == 7), "oneshot_count");
         chk(2'd0, (k == 7) ? 32'h19 : 32'h9, (k == 7), "oneshot_ctrl");
      end
      step(1);
      chk(2'd0, 32'h18, 1'b1, "oneshot_en_cleared");
      chk(2'd2, 32'd0, 1'b1, "oneshot_count_zero");
      wr(2'd0, 32'h0);
      chk(2'd0, 32'h0, 1'b0, "oneshot_irq_drop");

      // PRESET=0 reaches INT on the first CNT edge (E3)
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      step(2);
      chk(2'd0, 32'h9, 1'b0, "preset0_e2");
      step(1);
      chk(2'd0, 32'h19, 1'b1, "preset0_e3");
      wr(2'd0, 32'h0);
      step(2);

      // Auto-reload, PRESET=3; pend cleared by a CTRL write at E6 and set again at E10
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 11; k++) begin
         if (k == 6) wr(2'd0, 32'hB);
         else        step(1);
         chk(2'd2, cnt_tab[k-1], ctrl_tab[k-1][4], "reload_count");
         chk(2'd0, ctrl_tab[k-1], ctrl_tab[k-1][4], "reload_ctrl");
      end
      wr(2'd0, 32'h0);
      step(1);

      // Masked auto-reload: PEND visible, irq stays low
      wr(2'd0, 32'h3);
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk(2'd0, (k == 5) ? 32'h13 : 32'h3, 1'b0, "masked_ctrl");
      end
      wr(2'd0, 32'h0);
      step(2);

      // Disable mid-count at COUNT=60, then re-enable reloads PRESET
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h1);
      step(41);
      wr(2'd0, 32'h0);
      chk(2'd2, 32'd60, 1'b0, "disable_count");
      chk(2'd0, 32'h0, 1'b0, "disable_ctrl");
      step(3);
      chk(2'd2, 32'd60, 1'b0, "disable_hold");
      wr(2'd0, 32'h1);
      step(1);
      chk(2'd2, 32'd60, 1'b0, "reenable_load");
      step(1);
      chk(2'd2, 32'd100, 1'b0, "reenable_reload");
      wr(2'd0, 32'h0);
      step(2);

      // CTRL write on the terminal-count edge: pend set wins
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      step(6);
      chk(2'd2, 32'd1, 1'b0, "collision_pre");
      wr(2'd0, 32'h9);
      chk(2'd0, 32'h19, 1'b1, "collision_pend");
      step(1);
      chk(2'd0, 32'h18, 1'b1, "collision_after");
      wr(2'd0, 32'h0);
      chk(2'd0, 32'h0, 1'b0, "collision_clear");

      // PRESET write at COUNT=10 only affects the next LOAD
      wr(2'd1, 32'd20);
      wr(2'd0, 32'hB);
      step(11);
      wr(2'd1, 32'd7);
      chk(2'd2, 32'd10, 1'b0, "preset_wr_count");
      chk(2'd1, 32'd7, 1'b0, "preset_wr_readback");
      step(9);
      chk(2'd2, 32'd1, 1'b0, "preset_wr_e21");
      step(1);
      chk(2'd2, 32'd0, 1'b1, "preset_wr_terminal");
      chk(2'd0, 32'h1B, 1'b1, "preset_wr_ctrl");
      step(2);
      chk(2'd2, 32'd7, 1'b1, "preset_wr_reload");
      wr(2'd0, 32'h0);
      step(1);
      chk(2'd2, 32'd6, 1'b0, "stop_count");

      // Ignored writes and CTRL field masking
      wr(2'd2, 32'h1234);
      chk(2'd2, 32'd6, 1'b0, "count_write_ignored");
      wr(2'd3, 32'hFFFF);
`ifdef TIMER_PRESCALE_EN
      psc_exp = 32'hFFFF;
`else
      psc_exp = 32'h0;
`endif
      chk(2'd3, psc_exp, 1'b0, "addr3_read");
      wr(2'd0, 32'hFFFF_FFE6);
      chk(2'd0, 32'h6, 1'b0, "ctrl_upper_bits");
      wr(2'd0, 32'h0);
      step(2);

`ifdef TIMER_PRESCALE_EN
      // PRESCALE=3, PRESET=2: irq at 2 + 2*4 = 10 edges after enable
      wr(2'd3, 32'd3);
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      step(9);
      chk(2'd0, 32'h9, 1'b0, "prescale_e9");
      step(1);
      chk(2'd0, 32'h19, 1'b1, "prescale_e10");
      chk(2'd3, 32'd3, 1'b1, "prescale_readback");
`endif

      #5;
      n_chk = n_chk + 1;
      if (nm_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL sb_leftover: %0d entries remain, expected 0", nm_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
